// File: rtl/led_frame_scheduler_if.sv
// led_frame_scheduler_if
// Groups the loader write port, the pixel-writer handshake and the frame
// status outputs of led_frame_scheduler.
//   master : the scheduler itself (drives px_*, frame_*, swap_ack, active_buf)
//   slave  : its environment (loader drives wr_*, pixel writer drives px_busy)
// Signals:
//   wr_en / wr_addr[3:0] / wr_data[7:0] : byte write into the back buffer
//   wr_commit                           : request a front/back swap
//   px_valid / px_value[7:0] / px_busy  : byte strobe to the pixel writer
//   frame_busy / frame_done             : frame in progress / frame finished
//   swap_ack / active_buf               : swap taken / current front bank
interface led_frame_scheduler_if;
  logic       wr_en;
  logic [3:0] wr_addr;
  logic [7:0] wr_data;
  logic       wr_commit;
  logic       px_valid;
  logic [7:0] px_value;
  logic       px_busy;
  logic       frame_busy;
  logic       frame_done;
  logic       swap_ack;
  logic       active_buf;

  modport master (
    input  wr_en, wr_addr, wr_data, wr_commit, px_busy,
    output px_valid, px_value, frame_busy, frame_done, swap_ack, active_buf
  );

  modport slave (
    output wr_en, wr_addr, wr_data, wr_commit, px_busy,
    input  px_valid, px_value, frame_busy, frame_done, swap_ack, active_buf
  );
endinterface

// File: rtl/led_frame_scheduler.sv
// led_frame_scheduler
// Streams complete frames (header byte + 16 front-buffer bytes) to the LED
// pixel writer. Two 16-byte banks are used ping-pong: the loader writes the
// back bank, a commit swaps the banks and starts a frame at once; otherwise a
// frame is sent on every refresh-counter wrap that finds the scheduler idle.
// Ports:
//   CLK  : clock
//   RST  : synchronous active-high reset (control state only, banks retained)
//   bus  : led_frame_scheduler_if.master (write port, writer handshake, status)
module led_frame_scheduler #(
  parameter int         REFRESH_CYCLES = 12_000_000,
  parameter logic [7:0] CMD_BYTE       = 8'hF1,
  parameter int         ACCEPT_TIMEOUT = 3
) (
  input  logic                   CLK,
  input  logic                   RST,
  led_frame_scheduler_if.master  bus
);

  localparam int               CNT_W    = $clog2(REFRESH_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_CYCLES - 1);
  localparam int               TO_W     = $clog2(ACCEPT_TIMEOUT + 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(ACCEPT_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_WAIT_HI,
    S_WAIT_LO,
    S_DATA,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [TO_W-1:0]  to_q, to_d;
  logic [3:0]       byte_idx_q, byte_idx_d;
  logic             hdr_q, hdr_d;
  logic             swap_pending_q, swap_pending_d;
  logic             active_buf_q, active_buf_d;
  logic             px_valid_q, px_valid_d;
  logic [7:0]       px_value_q, px_value_d;
  logic             frame_busy_q, frame_busy_d;
  logic             frame_done_q, frame_done_d;
  logic             swap_ack_q, swap_ack_d;
  logic [3:0]       nxt_idx;
  logic             tick;

  // Bank 0 occupies entries 0..15, bank 1 entries 16..31.
  logic [7:0] mem_q [32];

  // Free-running refresh counter; tick marks the wrap cycle.
  assign tick  = (cnt_q == CNT_LAST);
  assign cnt_d = tick ? '0 : cnt_q + 1'b1;

  always_comb begin
    state_d        = state_q;
    to_d           = to_q;
    byte_idx_d     = byte_idx_q;
    hdr_d          = hdr_q;
    active_buf_d   = active_buf_q;
    swap_pending_d = swap_pending_q | bus.wr_commit;
    px_valid_d     = 1'b0;
    px_value_d     = px_value_q;
    frame_busy_d   = frame_busy_q;
    frame_done_d   = 1'b0;
    swap_ack_d     = 1'b0;
    nxt_idx        = byte_idx_q + 4'd1;

    case (state_q)
      S_IDLE: begin
        // A pending swap takes priority and also absorbs a coincident tick.
        if (swap_pending_q) begin
          active_buf_d   = ~active_buf_q;
          swap_ack_d     = 1'b1;
          swap_pending_d = bus.wr_commit;
          state_d        = S_HDR;
        end else if (tick) begin
          state_d = S_HDR;
        end
      end
      S_HDR: begin
        byte_idx_d = 4'd0;
        hdr_d      = 1'b1;
        if (!bus.px_busy) begin
          px_value_d   = CMD_BYTE;
          px_valid_d   = 1'b1;
          frame_busy_d = 1'b1;
          to_d         = '0;
          state_d      = S_WAIT_HI;
        end
      end
      S_WAIT_HI: begin
        // A writer that never shows busy still lets the byte through.
        if (bus.px_busy || (to_q == TO_LAST)) begin
          state_d = S_WAIT_LO;
        end else begin
          to_d = to_q + 1'b1;
        end
      end
      S_WAIT_LO: begin
        if (!bus.px_busy) begin
          if (hdr_q || (byte_idx_q != 4'd15)) begin
            state_d = S_DATA;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_DATA: begin
        // First data byte after the header is index 0, later ones advance.
        if (hdr_q) begin
          nxt_idx = 4'd0;
        end
        byte_idx_d = nxt_idx;
        hdr_d      = 1'b0;
        px_value_d = mem_q[{active_buf_q, nxt_idx}];
        px_valid_d = 1'b1;
        to_d       = '0;
        state_d    = S_WAIT_HI;
      end
      S_DONE: begin
        frame_done_d = 1'b1;
        frame_busy_d = 1'b0;
        state_d      = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q        <= S_IDLE;
      cnt_q          <= '0;
      to_q           <= '0;
      byte_idx_q     <= 4'd0;
      hdr_q          <= 1'b0;
      swap_pending_q <= 1'b0;
      active_buf_q   <= 1'b0;
      px_valid_q     <= 1'b0;
      px_value_q     <= 8'h00;
      frame_busy_q   <= 1'b0;
      frame_done_q   <= 1'b0;
      swap_ack_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      to_q           <= to_d;
      byte_idx_q     <= byte_idx_d;
      hdr_q          <= hdr_d;
      swap_pending_q <= swap_pending_d;
      active_buf_q   <= active_buf_d;
      px_valid_q     <= px_valid_d;
      px_value_q     <= px_value_d;
      frame_busy_q   <= frame_busy_d;
      frame_done_q   <= frame_done_d;
      swap_ack_q     <= swap_ack_d;
    end
  end

  // Frame storage is data, not control: it is never reset. Writes always go
  // to the bank that is not currently being displayed.
  always_ff @(posedge CLK) begin
    if (bus.wr_en) begin
      mem_q[{~active_buf_q, bus.wr_addr}] <= bus.wr_data;
    end
  end

  assign bus.px_valid   = px_valid_q;
  assign bus.px_value   = px_value_q;
  assign bus.frame_busy = frame_busy_q;
  assign bus.frame_done = frame_done_q;
  assign bus.swap_ack   = swap_ack_q;
  assign bus.active_buf = active_buf_q;

endmodule

// File: tb/tb_led_frame_scheduler.sv
// tb_led_frame_scheduler
// Self-checking bench for led_frame_scheduler: a pixel-writer model answers
// the strobes, a monitor records strobes and status pulses, and a bank-level
// reference model (two 16-byte arrays plus the expected front index) gives
// the expected content of every frame.
module tb_led_frame_scheduler;
  localparam int         RC       = 32;
  localparam logic [7:0] CMD      = 8'hF1;
  localparam int         AT       = 3;
  localparam int         BUSY_LEN = 4;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  led_frame_scheduler_if bus();

  led_frame_scheduler #(
    .REFRESH_CYCLES (RC),
    .CMD_BYTE       (CMD),
    .ACCEPT_TIMEOUT (AT)
  ) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  int pass_cnt = 0;
  int total_cnt = 0;
  int timeouts = 0;

  // Reference model: bank contents and which bank is expected in front.
  logic [7:0] mbank [2][16];
  int         mact = 0;

  function automatic logic [7:0] exp_byte(int b, int i);
    return (i == 0) ? CMD : mbank[b][i-1];
  endfunction

  // Pixel writer model: busy for BUSY_LEN cycles after each accepted strobe.
  bit   writer_on = 1'b1;
  int   busy_cnt = 0;
  logic busy_r = 1'b0;
  assign bus.px_busy = busy_r;

  always @(posedge CLK) begin
    int n;
    n = busy_cnt;
    if (n > 0) n--;
    if (writer_on && bus.px_valid) n = BUSY_LEN;
    busy_cnt <= n;
    busy_r   <= (n != 0);
  end

  // Monitor
  int         cyc = 0;
  logic [7:0] strobes [$];
  int         strobe_cyc [$];
  int         done_cnt = 0, done_cyc = 0, swap_cnt = 0, swap_cyc = 0;
  int         viol = 0, min_gap = 1000, last_strobe = -100;
  bit         prev_valid = 1'b0;

  always @(posedge CLK) cyc <= cyc + 1;

  always @(negedge CLK) begin
    if (bus.px_valid) begin
      strobes.push_back(bus.px_value);
      strobe_cyc.push_back(cyc);
      if (bus.px_busy) viol++;
      if (prev_valid) viol++;
      if (cyc - last_strobe < min_gap) min_gap = cyc - last_strobe;
      last_strobe = cyc;
    end
    prev_valid = bus.px_valid;
    if (bus.frame_done) begin done_cnt++; done_cyc = cyc; end
    if (bus.swap_ack) begin swap_cnt++; swap_cyc = cyc; end
  end

  // Bounded waits; an expired bound is counted and reported in test_protocol.
  task automatic tick_n(int n);
    repeat (n) begin @(negedge CLK); #1; end
  endtask

  task automatic wait_done(int budget);
    int d0;
    d0 = done_cnt;
    for (int i = 0; i < budget; i++) begin
      @(negedge CLK); #1;
      if (done_cnt != d0) return;
    end
    timeouts++;
  endtask

  task automatic wait_swap(int budget);
    int s0;
    s0 = swap_cnt;
    for (int i = 0; i < budget; i++) begin
      @(negedge CLK); #1;
      if (swap_cnt != s0) return;
    end
    timeouts++;
  endtask

  task automatic wait_strobes(int n, int budget);
    for (int i = 0; i < budget; i++) begin
      if (strobes.size() >= n) return;
      @(negedge CLK); #1;
    end
    if (strobes.size() < n) timeouts++;
  endtask

  task automatic clear_strobes;
    strobes.delete();
    strobe_cyc.delete();
  endtask

  task automatic sync_frame;
    wait_done(400);
    clear_strobes();
  endtask

  task automatic do_write(logic [3:0] a, logic [7:0] d);
    bus.wr_en   = 1'b1;
    bus.wr_addr = a;
    bus.wr_data = d;
    mbank[1-mact][a] = d;
    tick_n(1);
    bus.wr_en = 1'b0;
  endtask

  task automatic do_commit;
    bus.wr_commit = 1'b1;
    tick_n(1);
    bus.wr_commit = 1'b0;
  endtask

  task automatic test_reset;
    RST = 1'b1;
    bus.wr_en = 1'b0; bus.wr_addr = 4'd0; bus.wr_data = 8'h00; bus.wr_commit = 1'b0;
    tick_n(4);
    mact = 0;
    total_cnt++; if (bus.px_valid !== 1'b0) $display("FAIL rst_px_valid got %b want 0", bus.px_valid); else pass_cnt++;
    total_cnt++; if (bus.px_value !== 8'h00) $display("FAIL rst_px_value got %h want 00", bus.px_value); else pass_cnt++;
    total_cnt++; if (bus.frame_busy !== 1'b0) $display("FAIL rst_frame_busy got %b want 0", bus.frame_busy); else pass_cnt++;
    total_cnt++; if (bus.frame_done !== 1'b0) $display("FAIL rst_frame_done got %b want 0", bus.frame_done); else pass_cnt++;
    total_cnt++; if (bus.swap_ack !== 1'b0) $display("FAIL rst_swap_ack got %b want 0", bus.swap_ack); else pass_cnt++;
    total_cnt++; if (bus.active_buf !== 1'b0) $display("FAIL rst_active_buf got %b want 0", bus.active_buf); else pass_cnt++;
  endtask

  // Commit in IDLE right after reset: back bank 1 holds 10..1F.
  task automatic test_swap_commit;
    int cc, bad, hc;
    RST = 1'b0;
    for (int a = 0; a < 16; a++) do_write(4'(a), 8'(16 + a));
    clear_strobes();
    cc = cyc;
    do_commit();
    wait_swap(10);
    total_cnt++; if (swap_cyc - cc !== 2) $display("FAIL swap_ack_latency got %0d want 2", swap_cyc - cc); else pass_cnt++;
    total_cnt++; if (bus.active_buf !== 1'b1) $display("FAIL swap_active_buf got %b want 1", bus.active_buf); else pass_cnt++;
    mact = 1;
    wait_strobes(1, 10);
    hc = (strobe_cyc.size() > 0) ? strobe_cyc[0] - cc : -1;
    total_cnt++; if (hc !== 3) $display("FAIL swap_hdr_latency got %0d want 3", hc); else pass_cnt++;
    wait_done(400);
    total_cnt++; if (strobes.size() !== 17) $display("FAIL swap_frame_len got %0d want 17", strobes.size()); else pass_cnt++;
    bad = -1;
    for (int i = 0; i < 17 && i < strobes.size(); i++) if (bad < 0 && strobes[i] !== exp_byte(1, i)) bad = i;
    total_cnt++;
    if (bad >= 0) $display("FAIL swap_frame_data byte %0d got %h want %h", bad, strobes[bad], exp_byte(1, bad));
    else pass_cnt++;
  endtask

  // Fill bank 0 with random bytes and bring it to the front.
  task automatic preload_bank0;
    for (int a = 0; a < 16; a++) do_write(4'(a), 8'($urandom_range(0, 255)));
    do_commit();
    wait_swap(400);
    mact = 0;
    total_cnt++; if (bus.active_buf !== 1'b0) $display("FAIL preload_active_buf got %b want 0", bus.active_buf); else pass_cnt++;
  endtask

  // Reset, then the first frame comes from the refresh wrap.
  task automatic test_refresh;
    int c0, d0, bad, hc;
    RST = 1'b1;
    tick_n(2);
    RST = 1'b0;
    c0 = cyc;
    d0 = done_cnt;
    mact = 0;
    clear_strobes();
    wait_strobes(1, 100);
    hc = (strobe_cyc.size() > 0) ? strobe_cyc[0] - c0 : -1;
    total_cnt++; if (hc !== RC + 1) $display("FAIL tick_hdr_latency got %0d want %0d", hc, RC + 1); else pass_cnt++;
    total_cnt++; if (bus.frame_busy !== 1'b1) $display("FAIL tick_frame_busy got %b want 1", bus.frame_busy); else pass_cnt++;
    wait_done(400);
    total_cnt++; if (done_cnt - d0 !== 1) $display("FAIL tick_done_count got %0d want 1", done_cnt - d0); else pass_cnt++;
    tick_n(1);
    total_cnt++; if (bus.frame_done !== 1'b0) $display("FAIL tick_done_pulse got %b want 0", bus.frame_done); else pass_cnt++;
    total_cnt++; if (strobes.size() !== 17) $display("FAIL tick_frame_len got %0d want 17", strobes.size()); else pass_cnt++;
    bad = -1;
    for (int i = 0; i < 17 && i < strobes.size(); i++) if (bad < 0 && strobes[i] !== exp_byte(0, i)) bad = i;
    total_cnt++;
    if (bad >= 0) $display("FAIL tick_frame_data byte %0d got %h want %h", bad, strobes[bad], exp_byte(0, bad));
    else pass_cnt++;
  endtask

  // Reset on the 8th data strobe aborts the frame cleanly.
  task automatic test_reset_mid_frame;
    int c0, d0, bad, hc;
    sync_frame();
    wait_strobes(9, 200);
    RST = 1'b1;
    tick_n(1);
    total_cnt++; if (bus.px_valid !== 1'b0) $display("FAIL abort_px_valid got %b want 0", bus.px_valid); else pass_cnt++;
    total_cnt++; if (bus.frame_busy !== 1'b0) $display("FAIL abort_frame_busy got %b want 0", bus.frame_busy); else pass_cnt++;
    RST = 1'b0;
    c0 = cyc;
    d0 = done_cnt;
    mact = 0;
    clear_strobes();
    wait_strobes(1, 100);
    hc = (strobe_cyc.size() > 0) ? strobe_cyc[0] - c0 : -1;
    total_cnt++; if (hc !== RC + 1) $display("FAIL abort_resume_latency got %0d want %0d", hc, RC + 1); else pass_cnt++;
    total_cnt++; if (done_cnt !== d0) $display("FAIL abort_no_done got %0d want %0d", done_cnt, d0); else pass_cnt++;
    wait_done(400);
    bad = (strobes.size() == 17) ? -1 : 0;
    for (int i = 0; i < 17 && i < strobes.size(); i++) if (bad < 0 && strobes[i] !== exp_byte(0, i)) bad = i;
    total_cnt++;
    if (bad >= 0) $display("FAIL abort_frame_data byte %0d got %h want %h (len %0d)", bad,
                           (bad < strobes.size()) ? strobes[bad] : 8'h00, exp_byte(0, bad), strobes.size());
    else pass_cnt++;
  endtask

  // Commit at the 5th data byte is deferred until the frame finishes.
  task automatic test_deferred_commit;
    int s0, bad;
    for (int a = 0; a < 16; a++) do_write(4'(a), 8'($urandom_range(0, 255)));
    sync_frame();
    wait_strobes(6, 200);
    s0 = swap_cnt;
    do_commit();
    wait_done(400);
    total_cnt++; if (swap_cnt !== s0) $display("FAIL defer_early_swap got %0d want %0d", swap_cnt, s0); else pass_cnt++;
    bad = (strobes.size() == 17) ? -1 : 0;
    for (int i = 0; i < 17 && i < strobes.size(); i++) if (bad < 0 && strobes[i] !== exp_byte(0, i)) bad = i;
    total_cnt++;
    if (bad >= 0) $display("FAIL defer_old_frame byte %0d got %h want %h (len %0d)", bad,
                           (bad < strobes.size()) ? strobes[bad] : 8'h00, exp_byte(0, bad), strobes.size());
    else pass_cnt++;
    clear_strobes();
    wait_swap(10);
    total_cnt++; if (swap_cyc - done_cyc !== 1) $display("FAIL defer_swap_after_done got %0d want 1", swap_cyc - done_cyc); else pass_cnt++;
    total_cnt++; if (bus.active_buf !== 1'b1) $display("FAIL defer_active_buf got %b want 1", bus.active_buf); else pass_cnt++;
    mact = 1;
    wait_done(400);
    bad = (strobes.size() == 17) ? -1 : 0;
    for (int i = 0; i < 17 && i < strobes.size(); i++) if (bad < 0 && strobes[i] !== exp_byte(1, i)) bad = i;
    total_cnt++;
    if (bad >= 0) $display("FAIL defer_new_frame byte %0d got %h want %h (len %0d)", bad,
                           (bad < strobes.size()) ? strobes[bad] : 8'h00, exp_byte(1, bad), strobes.size());
    else pass_cnt++;
  endtask

  // Writer never raises busy: every byte advances on the accept timeout.
  task automatic test_timeout;
    int bad;
    writer_on = 1'b0;
    sync_frame();
    wait_done(400);
    total_cnt++; if (strobes.size() !== 17) $display("FAIL timeout_frame_len got %0d want 17", strobes.size()); else pass_cnt++;
    bad = -1;
    for (int i = 0; i < 17 && i < strobes.size(); i++) if (bad < 0 && strobes[i] !== exp_byte(mact, i)) bad = i;
    total_cnt++;
    if (bad >= 0) $display("FAIL timeout_frame_data byte %0d got %h want %h", bad, strobes[bad], exp_byte(mact, bad));
    else pass_cnt++;
    writer_on = 1'b1;
  endtask

  // Two commits in one frame collapse to one swap; write on the commit cycle lands.
  task automatic test_double_commit;
    int s0, bad;
    logic [7:0] b4;
    sync_frame();
    wait_strobes(3, 200);
    s0 = swap_cnt;
    do_write(4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)));
    do_write(4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)));
    do_commit();
    tick_n(3);
    bus.wr_en = 1'b1; bus.wr_addr = 4'd3; bus.wr_data = 8'hA5; bus.wr_commit = 1'b1;
    mbank[1-mact][3] = 8'hA5;
    tick_n(1);
    bus.wr_en = 1'b0; bus.wr_commit = 1'b0;
    wait_done(400);
    clear_strobes();
    mact = 0;
    wait_done(400);
    total_cnt++; if (swap_cnt - s0 !== 1) $display("FAIL dbl_swap_count got %0d want 1", swap_cnt - s0); else pass_cnt++;
    b4 = (strobes.size() > 4) ? strobes[4] : 8'h00;
    total_cnt++; if (b4 !== 8'hA5) $display("FAIL dbl_byte3 got %h want a5", b4); else pass_cnt++;
    bad = (strobes.size() == 17) ? -1 : 0;
    for (int i = 0; i < 17 && i < strobes.size(); i++) if (bad < 0 && strobes[i] !== exp_byte(0, i)) bad = i;
    total_cnt++;
    if (bad >= 0) $display("FAIL dbl_frame_data byte %0d got %h want %h (len %0d)", bad,
                           (bad < strobes.size()) ? strobes[bad] : 8'h00, exp_byte(0, bad), strobes.size());
    else pass_cnt++;
    wait_done(400);
    total_cnt++; if (swap_cnt - s0 !== 1) $display("FAIL dbl_no_second_swap got %0d want 1", swap_cnt - s0); else pass_cnt++;
    total_cnt++; if (bus.active_buf !== 1'b0) $display("FAIL dbl_active_buf got %b want 0", bus.active_buf); else pass_cnt++;
  endtask

  task automatic test_protocol;
    total_cnt++; if (viol !== 0) $display("FAIL proto_violations got %0d want 0", viol); else pass_cnt++;
    total_cnt++; if (min_gap < 3) $display("FAIL proto_min_gap got %0d want >=3", min_gap); else pass_cnt++;
    total_cnt++; if (timeouts !== 0) $display("FAIL proto_wait_timeouts got %0d want 0", timeouts); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_swap_commit();
    preload_bank0();
    test_refresh();
    test_reset_mid_frame();
    test_deferred_commit();
    test_timeout();
    test_double_commit();
    test_protocol();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/led_frame_scheduler.md
# led_frame_scheduler

Sequences complete frames into the LED-array pixel writer (`writepixels`). It replaces the hard-wired per-second sequencer in the board top. It owns two 16-byte frame buffers (front/back, ping-pong) and accepts byte writes into the back buffer from an upstream loader (UART parser or pattern generator). It streams header byte + 16 front-buffer bytes to the writer over its valid/value/busy handshake, either on a periodic refresh tick or immediately after a buffer swap.

## Interface
Parameters:
- REFRESH_CYCLES, 12_000_000 — refresh period in CLK cycles (1 s at 12 MHz); minimum 32.
- CMD_BYTE, 8'hF1 — header byte sent before every frame.
- ACCEPT_TIMEOUT, 3 — cycles to wait for writer `busy` to rise after a valid pulse.

Ports:
- CLK  in  1  system clock; the block's only clock.
- RST  in  1  synchronous, active-high reset.
- wr_en  in  1  write one byte into the back buffer.
- wr_addr  in  4  back-buffer byte index 0..15.
- wr_data  in  8  byte to write.
- wr_commit  in  1  request front/back swap (single-cycle pulse).
- px_valid  out  1  one-cycle strobe to the writer: px_value is a new byte.
- px_value  out  8  byte to the writer; held stable until the next strobe.
- px_busy  in  1  writer busy (high while shifting a byte out).
- frame_busy  out  1  high from the header strobe until the frame completes.
- frame_done  out  1  one-cycle pulse after the last data byte is accepted.
- swap_ack  out  1  one-cycle pulse on the cycle the swap takes effect.
- active_buf  out  1  index of the current front buffer.

## Operation
- Storage: two banks of 16×8. Writes always target bank `~active_buf`. The front bank is never written.
- Refresh counter: counts 0..REFRESH_CYCLES-1 and wraps, raising an internal `tick` on the wrap cycle. It free-runs, including during frames.
- `swap_pending`: set by wr_commit and cleared when the swap is applied. Multiple commits before the swap collapse into one.
- FSM states:
  - IDLE. If swap_pending: toggle active_buf, pulse swap_ack, clear swap_pending, go to HDR. Else if tick: go to HDR. Otherwise stay.
  - HDR. Load byte_idx=0. Once px_busy==0, drive px_value=CMD_BYTE, px_valid=1, frame_busy=1, and go to WAIT_HI.
  - WAIT_HI. Wait for px_busy==1, or ACCEPT_TIMEOUT cycles without it (the byte is then treated as accepted). Go to WAIT_LO.
  - WAIT_LO. Wait for px_busy==0. If the byte just accepted was the header or byte_idx<15, go to DATA. Else go to DONE.
  - DATA. Drive px_value=front[byte_idx] and px_valid=1. Increment byte_idx, except on the first data byte after the header, which uses index 0. Go to WAIT_HI.
  - DONE. Pulse frame_done, drop frame_busy, go to IDLE.
- Each frame is exactly 17 strobes: CMD_BYTE, then front[0]..front[15] in order.
- Ticks arriving outside IDLE are dropped; no queued refresh.
- A commit during a frame is deferred. The in-flight frame finishes from the old front bank; the swap happens in the IDLE cycle after DONE, followed immediately by a new frame.
- A write in the same cycle as wr_commit lands in the pre-swap back bank, so it is visible in the new front frame.
- A tick and swap_pending in IDLE together produce one frame (the swap path).
- Buffer contents are not cleared by reset (X/init-value tolerated). Reset clears only the control state.

## Timing
- Reset values: px_valid=0, px_value=8'h00, frame_busy=0, frame_done=0, swap_ack=0, active_buf=0, swap_pending=0, refresh counter=0, FSM=IDLE, byte_idx=0.
- RST asserted mid-frame aborts it on the next edge. No further px_valid is issued; frame_busy drops and no frame_done is generated.
- px_valid is never high on two consecutive cycles.
- px_valid is never asserted while px_busy==1.
- Minimum spacing between strobes is 3 cycles (strobe, WAIT_HI, WAIT_LO).
- Swap-to-header latency: wr_commit at edge N in IDLE → swap_ack at N+1 → header strobe at N+2 (if px_busy==0).
- Tick-to-header: header strobe 2 cycles after the wrap cycle.
- Write latency: a byte written at edge N is readable after that edge.

## Test plan
- Reset, REFRESH_CYCLES=32, writer model busy for 4 cycles per byte → first frame starts after the counter wraps; strobes are F1, then 16 bytes of X-free preloaded data; frame_done pulses once; no strobe while busy.
- Write back-bank bytes 0..15 = 8'h10..8'h1F, pulse wr_commit in IDLE → swap_ack next cycle, active_buf=1, frame strobes F1,10,11,…,1F.
- Pulse wr_commit at the 5th data byte of an active frame → that frame completes with the old data; swap_ack one cycle after frame_done; the next frame carries the new data.
- Writer model that never raises busy → each byte advances after ACCEPT_TIMEOUT; the frame still emits exactly 17 strobes.
- Assert RST at the 8th data strobe → px_valid stays 0, frame_busy=0, no frame_done; normal refresh resumes after the next wrap.
- Commit twice, plus a write on the commit cycle (addr 3, 8'hA5) → a single swap; new frame byte 3 = A5.
